// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand/result bundle between a requester and the serial adder
interface serial_adder_if #(parameter int WIDTH = 8) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin using one full adder, LSB first, WIDTH shift cycles
module serial_adder #(parameter int WIDTH = 8) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nx, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q, s, co, last, accept;
    always_comb begin
        s        = a_sr[0] ^ b_sr[0] ^ carry;
        co       = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        s_nx     = {s, {(WIDTH-1){1'b0}}} | (s_sr >> 1);
        last     = cnt == CW'(WIDTH - 1);
        accept   = state == IDLE && bus.start;
        state_nx = accept ? SHIFT : (state == SHIFT && last) ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;
    // sum/cout only update on the final shift so partial values never show
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_nx;
            carry <= co;
            cnt   <= cnt + 1'b1;
            if (last) begin
                sum_q  <= s_nx;
                cout_q <= co;
            end
        end
    end
    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
